// File: rtl/enq_pkt_desc_tx.sv
// Prefetch-FIFO to queue-manager descriptor transmitter with credit flow control.
// Optional statistics counters are enabled by defining ENQ_PKT_DESC_TX_STATS_EN.
module enq_pkt_desc_tx #(
   parameter int  CREDITS           = 16,
   parameter int  CREDIT_NBITS      = 8,
   parameter int  STAT_NBITS        = 32,
   parameter type enq_pkt_desc_type = logic [63:0]
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    fifo_empty,
   input  enq_pkt_desc_type        fifo_dout,
   output logic                    fifo_rd,
   output logic                    enq_valid,
   output enq_pkt_desc_type        enq_desc,
   input  logic                    enq_ready,
   input  logic                    credit_ret,
   input  logic                    flush,
   output logic [CREDIT_NBITS-1:0] credit_cnt,
   output logic                    credit_err
`ifdef ENQ_PKT_DESC_TX_STATS_EN
   ,
   output logic [STAT_NBITS-1:0]   stat_tx_cnt,
   output logic [STAT_NBITS-1:0]   stat_stall_cnt
`endif
);

   localparam int CW = CREDIT_NBITS + 2;

   if (CREDITS < 1 || CREDITS > 255 || CREDITS >= (1 << CREDIT_NBITS) || STAT_NBITS < 1) begin : g_bad_param
      $error("enq_pkt_desc_tx: illegal CREDITS/CREDIT_NBITS/STAT_NBITS");
   end

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state;
   logic          refund;
   logic          over;
   logic [CW-1:0] cnt_sum;

   // Pop only when the slot frees this cycle: either nothing is held or it is being taken.
   assign fifo_rd = rstn & ~fifo_empty & (credit_cnt != '0) & ~flush & ((state == IDLE) | enq_ready);
   // A flushed descriptor never reached the queue manager, so its credit comes back.
   assign refund  = flush & (state == SEND) & ~enq_ready;

   always_comb begin
      cnt_sum = {2'b00, credit_cnt} + CW'(credit_ret) + CW'(refund) - CW'(fifo_rd);
      over    = cnt_sum > CW'(CREDITS);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         enq_valid  <= 1'b0;
         enq_desc   <= '0;
         credit_cnt <= CREDIT_NBITS'(CREDITS);
         credit_err <= 1'b0;
      end else begin
         credit_cnt <= over ? CREDIT_NBITS'(CREDITS) : cnt_sum[CREDIT_NBITS-1:0];
         if (over)
            credit_err <= 1'b1;
         if (fifo_rd)
            enq_desc <= fifo_dout;
         case (state)
            IDLE: if (fifo_rd) begin
               state     <= SEND;
               enq_valid <= 1'b1;
            end
            SEND: if (!fifo_rd && (enq_ready || flush)) begin
               state     <= IDLE;
               enq_valid <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               enq_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef ENQ_PKT_DESC_TX_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_tx_cnt    <= '0;
         stat_stall_cnt <= '0;
      end else begin
         if (enq_valid && enq_ready)
            stat_tx_cnt <= stat_tx_cnt + 1'b1;
         if (!fifo_empty && credit_cnt == '0)
            stat_stall_cnt <= stat_stall_cnt + 1'b1;
      end
   end
`endif

endmodule
